led_blink_scheduler: RTL and testbench

Shares the single board LED between N_REQ independent requesters, each asking for a burst of blinks.
- Arbitrates pending requests round-robin.
- Sequences the granted burst on led1, with a fixed on/off timing.
- Inserts a guard gap with the LED dark before serving the next requester.
- Sits between status/event logic and the LED pin.

---
 rtl/led_pkg.sv | 13 +
 rtl/led_rr_arbiter.sv | 29 ++
 rtl/led_blink_scheduler.sv | 174 +++++++++++++++++
 tb/tb_led_blink_scheduler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and default timing constants for the LED blink scheduler.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLINK = 2'd1,
        GAP   = 2'd2
    } e_sched_state;

    localparam int HALF_PERIOD_DEF = 16_666_666;
    localparam int GAP_CYC_DEF     = 50_000_000;

endpackage

// File: rtl/led_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above ptr, with wrap.
module led_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] index,
    output logic [N_REQ-1:0] onehot
);

    always_comb begin
        valid  = 1'b0;
        index  = '0;
        onehot = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int j;
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!valid && req[j]) begin
                valid     = 1'b1;
                index     = IDX_W'(j);
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_blink_scheduler.sv
// Shares one active-low LED between N_REQ requesters: round-robin grant, blink burst, dark guard gap.
// Optional LED_SCHED_PREEMPT_EN: requester 0 wins arbitration and cuts other bursts at an off-phase end.
module led_blink_scheduler
    import led_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int HALF_PERIOD = HALF_PERIOD_DEF,
    parameter int GAP_CYC     = GAP_CYC_DEF,
    parameter int CNT_W       = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] req_blinks,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic                   led1,
    output e_sched_state           dbg_state
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PH_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(HALF_PERIOD - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    e_sched_state     state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] blinks_q, blinks_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             led_q, led_d;

    logic             arb_valid;
    logic [IDX_W-1:0] arb_idx;
    logic [N_REQ-1:0] arb_onehot;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_onehot;
    logic [CNT_W-1:0] pick_blinks;

    led_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .valid  (arb_valid),
        .index  (arb_idx),
        .onehot (arb_onehot)
    );

    always_comb begin
        pick_valid  = arb_valid;
        pick_idx    = arb_idx;
        pick_onehot = arb_onehot;
`ifdef LED_SCHED_PREEMPT_EN
        if (req[0]) begin
            pick_valid  = 1'b1;
            pick_idx    = '0;
            pick_onehot = N_REQ'(1);
        end
`endif
        pick_blinks = req_blinks[int'(pick_idx)*CNT_W +: CNT_W];
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        blinks_d = blinks_q;
        phase_d  = phase_q;
        gap_d    = gap_q;
        grant_d  = grant_q;
        done_d   = '0;
        led_d    = led_q;
        case (state_q)
            IDLE: begin
                led_d   = 1'b1;
                grant_d = '0;
                if (pick_valid) begin
                    grant_d  = pick_onehot;
                    ptr_d    = (pick_idx == IDX_LAST) ? '0 : pick_idx + 1'b1;
                    blinks_d = pick_blinks;
                    phase_d  = '0;
                    gap_d    = '0;
                    if (pick_blinks != '0) begin
                        state_d = BLINK;
                        led_d   = 1'b0;
                    end else begin
                        // Empty burst: acknowledge at once, still pay the guard gap.
                        done_d  = pick_onehot;
                        state_d = GAP;
                    end
                end
            end
            BLINK: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (led_q) begin
                        blinks_d = blinks_q - 1'b1;
                        if (blinks_q == CNT_W'(1)) begin
                            done_d  = grant_q;
                            grant_d = '0;
                            led_d   = 1'b1;
                            gap_d   = '0;
                            state_d = GAP;
`ifdef LED_SCHED_PREEMPT_EN
                        end else if (req[0] && !grant_q[0]) begin
                            // Cut without done; the requester keeps req high and is re-served in full.
                            grant_d = '0;
                            led_d   = 1'b1;
                            gap_d   = '0;
                            state_d = GAP;
`endif
                        end else begin
                            led_d = 1'b0;
                        end
                    end else begin
                        led_d = 1'b1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            GAP: begin
                grant_d = '0;
                led_d   = 1'b1;
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                led_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            blinks_q <= '0;
            phase_q  <= '0;
            gap_q    <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            led_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            blinks_q <= blinks_d;
            phase_q  <= phase_d;
            gap_q    <= gap_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            led_q    <= led_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign led1      = led_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Directed bench for led_blink_scheduler with N_REQ=4, HALF_PERIOD=4, GAP_CYC=3, CNT_W=4.
module tb_led_blink_scheduler;
    import led_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [15:0]  req_blinks;
    logic [3:0]   grant;
    logic [3:0]   done;
    logic         busy;
    logic         led1;
    e_sched_state dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    led_blink_scheduler #(
        .N_REQ       (4),
        .HALF_PERIOD (4),
        .GAP_CYC     (3),
        .CNT_W       (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_blinks (req_blinks),
        .grant      (grant),
        .done       (done),
        .busy       (busy),
        .led1       (led1),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] seq [5];
        int         on_cnt;

        // Test 1: reset state and quiet idle
        reset      = 1'b0;
        req        = '0;
        req_blinks = '0;
        step();
        step();
        chk("rst_led1", 32'(led1), 1);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("idle_led1", 32'(led1), 1);
            chk("idle_grant", 32'(grant), 0);
            chk("idle_busy", 32'(busy), 0);
        end

        // Test 2: single requester, two blinks
        req_blinks = 16'h0002;
        req        = 4'b0001;
        step();
        chk("t2_grant", 32'(grant), 4'b0001);
        chk("t2_busy", 32'(busy), 1);
        for (int k = 1; k <= 16; k++) begin
            chk("t2_led1", 32'(led1), (((k - 1) / 4) % 2 == 1) ? 1 : 0);
            chk("t2_nodone", 32'(done), 0);
            step();
        end
        chk("t2_done", 32'(done), 4'b0001);
        chk("t2_grant_off", 32'(grant), 0);
        chk("t2_led_done", 32'(led1), 1);
        req = '0;
        step();
        chk("t2_done_pulse", 32'(done), 0);
        step();
        chk("t2_busy_gap", 32'(busy), 1);
        step();
        chk("t2_busy_idle", 32'(busy), 0);

        // Test 3: all requesters, one blink each, round-robin order
        do_reset();
        req_blinks = 16'h1111;
        req        = 4'b1111;
`ifdef LED_SCHED_PREEMPT_EN
        seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        step();
        for (int g = 0; g < 5; g++) begin
            chk("t3_grant", 32'(grant), 32'(seq[g]));
            repeat (8) step();
            chk("t3_done", 32'(done), 32'(seq[g]));
            if (g == 4) req = '0;
            repeat (4) step();
        end

        // Test 4: zero-count burst
        do_reset();
        req_blinks = 16'h0000;
        req        = 4'b0100;
        step();
        chk("t4_grant", 32'(grant), 4'b0100);
        chk("t4_done", 32'(done), 4'b0100);
        chk("t4_led1", 32'(led1), 1);
        chk("t4_state", 32'(dbg_state), 32'(GAP));
        step();
        chk("t4_grant_off", 32'(grant), 0);
        chk("t4_done_off", 32'(done), 0);
        chk("t4_led1_gap", 32'(led1), 1);
        step();
        step();
        chk("t4_busy_idle", 32'(busy), 0);
        chk("t4_grant_idle", 32'(grant), 0);
        step();
        chk("t4_regrant", 32'(grant), 4'b0100);
        chk("t4_redone", 32'(done), 4'b0100);
        req = '0;

        // Test 5: reset mid-burst, then full re-service
        do_reset();
        req_blinks = 16'h0050;
        req        = 4'b0010;
        step();
        chk("t5_grant", 32'(grant), 4'b0010);
        for (int k = 1; k <= 6; k++) begin
            chk("t5_led1", 32'(led1), (k <= 4) ? 0 : 1);
            step();
        end
        reset = 1'b0;
        step();
        chk("t5_abort_led1", 32'(led1), 1);
        chk("t5_abort_grant", 32'(grant), 0);
        chk("t5_abort_done", 32'(done), 0);
        chk("t5_abort_busy", 32'(busy), 0);
        reset = 1'b1;
        step();
        chk("t5_regrant", 32'(grant), 4'b0010);
        on_cnt = 0;
        for (int k = 9; k <= 48; k++) begin
            if (led1 == 1'b0) on_cnt++;
            chk("t5_nodone", 32'(done), 0);
            step();
        end
        chk("t5_on_cycles", 32'(on_cnt), 20);
        chk("t5_done", 32'(done), 4'b0010);
        chk("t5_grant_off", 32'(grant), 0);
        req = '0;
        repeat (4) step();

`ifdef LED_SCHED_PREEMPT_EN
        // Test 6: requester 0 preempts requester 2
        do_reset();
        req_blinks = 16'h0301;
        req        = 4'b0100;
        step();
        chk("t6_grant2", 32'(grant), 4'b0100);
        repeat (9) step();
        chk("t6_led_on2", 32'(led1), 0);
        req = 4'b0101;
        repeat (2) step();
        chk("t6_led_on2_end", 32'(led1), 0);
        repeat (4) step();
        chk("t6_led_off2", 32'(led1), 1);
        chk("t6_grant_hold", 32'(grant), 4'b0100);
        step();
        chk("t6_cut_grant", 32'(grant), 0);
        chk("t6_cut_nodone", 32'(done), 0);
        chk("t6_cut_state", 32'(dbg_state), 32'(GAP));
        repeat (4) step();
        chk("t6_grant0", 32'(grant), 4'b0001);
        repeat (8) step();
        chk("t6_done0", 32'(done), 4'b0001);
        req = 4'b0100;
        repeat (4) step();
        chk("t6_regrant2", 32'(grant), 4'b0100);
        for (int k = 0; k < 23; k++) begin
            step();
            chk("t6_nodone2", 32'(done), 0);
        end
        step();
        chk("t6_done2", 32'(done), 4'b0100);
        req = '0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
